// File: rtl/tmds_word_aligner_if.sv
// ---------------------------------------------------------------------------
// tmds_word_aligner_if
// Groups one TMDS lane's data path and alignment status for tmds_word_aligner.
//
//   pdatain     : 10-bit word from the 1:10 deserializer, bit 0 first received
//   pdataout    : registered copy of pdatain
//   aligned     : lane locked to the word boundary
//   bitslip     : one-cycle pulse to the deserializer's bitslip input
//   slipcnt     : slips applied since reset, modulo 10
//   locklosscnt : LOCKED->SLIP transitions, saturating
//                 (present only with ALIGN_LOCKLOSSCNT_EN defined)
//
// Modports:
//   master : the aligner (consumes pdatain, drives everything else)
//   slave  : the surrounding lane logic / deserializer
// ---------------------------------------------------------------------------
interface tmds_word_aligner_if #(
    parameter int unsigned KPARALLELWIDTH = 10
);
    logic [KPARALLELWIDTH-1:0] pdatain;
    logic [KPARALLELWIDTH-1:0] pdataout;
    logic                      aligned;
    logic                      bitslip;
    logic [3:0]                slipcnt;
`ifdef ALIGN_LOCKLOSSCNT_EN
    logic [15:0]               locklosscnt;

    modport master (
        input  pdatain,
        output pdataout,
        output aligned,
        output bitslip,
        output slipcnt,
        output locklosscnt
    );

    modport slave (
        output pdatain,
        input  pdataout,
        input  aligned,
        input  bitslip,
        input  slipcnt,
        input  locklosscnt
    );
`else
    modport master (
        input  pdatain,
        output pdataout,
        output aligned,
        output bitslip,
        output slipcnt
    );

    modport slave (
        output pdatain,
        input  pdataout,
        input  aligned,
        input  bitslip,
        input  slipcnt
    );
`endif
endinterface

// File: rtl/tmds_word_aligner.sv
// ---------------------------------------------------------------------------
// tmds_word_aligner
// Receive-side word aligner for one TMDS/LVDS lane, in the pixel-clock domain
// right after the 1:10 deserializer. Looks for runs of TMDS control tokens and
// pulses bitslip to rotate the deserializer until the word boundary is found,
// then reports lock. Lock loss (no token for a full window) re-enters the
// slip/search loop automatically.
//
// Ports:
//   pixelclk : word-rate clock (only clock)
//   rst      : asynchronous, active-high reset
//   bus      : tmds_word_aligner_if.master
//              pdatain in, pdataout/aligned/bitslip/slipcnt out
//              (+ locklosscnt when ALIGN_LOCKLOSSCNT_EN is defined)
//
// Parameters:
//   KPARALLELWIDTH : word width, only 10 supported
//   KCTLTKNCOUNT   : consecutive control tokens needed to lock
//   KSEARCHCYCLES  : search window length; also the lock-loss timeout
//   KSETTLECYCLES  : wait after each bitslip before searching again (>=1)
//
// Optional feature macro: ALIGN_LOCKLOSSCNT_EN (adds locklosscnt[15:0]).
// ---------------------------------------------------------------------------
module tmds_word_aligner #(
    parameter int unsigned KPARALLELWIDTH = 10,
    parameter int unsigned KCTLTKNCOUNT   = 128,
    parameter int unsigned KSEARCHCYCLES  = 4096,
    parameter int unsigned KSETTLECYCLES  = 4
) (
    input  logic                pixelclk,
    input  logic                rst,
    tmds_word_aligner_if.master bus
);

    localparam int unsigned WCNT_W = (KSEARCHCYCLES > 1) ? $clog2(KSEARCHCYCLES) : 1;
    localparam int unsigned RCNT_W = $clog2(KCTLTKNCOUNT + 1);
    localparam int unsigned SCNT_W = (KSETTLECYCLES > 1) ? $clog2(KSETTLECYCLES) : 1;

    localparam logic [WCNT_W-1:0] WCNT_LAST    = WCNT_W'(KSEARCHCYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_FULL    = RCNT_W'(KCTLTKNCOUNT);
    localparam logic [RCNT_W-1:0] RCNT_PRELOCK = RCNT_W'(KCTLTKNCOUNT - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST    = SCNT_W'(KSETTLECYCLES - 1);

    localparam logic [KPARALLELWIDTH-1:0] TKN0 = KPARALLELWIDTH'(10'h354);
    localparam logic [KPARALLELWIDTH-1:0] TKN1 = KPARALLELWIDTH'(10'h0AB);
    localparam logic [KPARALLELWIDTH-1:0] TKN2 = KPARALLELWIDTH'(10'h154);
    localparam logic [KPARALLELWIDTH-1:0] TKN3 = KPARALLELWIDTH'(10'h2AB);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [WCNT_W-1:0]         r_wcnt;
    logic [RCNT_W-1:0]         r_rcnt;
    logic [SCNT_W-1:0]         r_scnt;

    logic [KPARALLELWIDTH-1:0] r_pdataout;
    logic                      r_aligned;
    logic                      r_bitslip;
    logic [3:0]                r_slipcnt;

    logic                      w_token;
    logic                      w_wcnt_last;
    logic                      w_run_done;
    logic                      w_settle_done;

    // ---------------------------------------------------------------------
    // Token detection and counter terminal conditions (all on current input)
    // ---------------------------------------------------------------------
    assign w_token = (bus.pdatain == TKN0) || (bus.pdatain == TKN1) ||
                     (bus.pdatain == TKN2) || (bus.pdatain == TKN3);

    assign w_wcnt_last   = (r_wcnt == WCNT_LAST);
    // The token sampled on this edge is the one that completes the run.
    assign w_run_done    = w_token && (r_rcnt == RCNT_PRELOCK);
    assign w_settle_done = (r_scnt == SCNT_LAST);

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge pixelclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next state. In SEARCH, lock is tested before the window timeout so
    // a run that completes on the timeout edge still locks.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: begin
                if (w_run_done) begin
                    w_state_nxt = ST_LOCKED;
                end else if (w_wcnt_last) begin
                    w_state_nxt = ST_SLIP;
                end
            end
            ST_SLIP: begin
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_done) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_LOCKED: begin
                if (!w_token && w_wcnt_last) begin
                    w_state_nxt = ST_SLIP;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Window, run and settle counters.
    // SLIP/SETTLE hold wcnt/rcnt at zero, which gives the "cleared on entry"
    // behaviour for SEARCH without a separate entry strobe.
    // ---------------------------------------------------------------------
    always_ff @(posedge pixelclk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
            r_rcnt <= '0;
            r_scnt <= '0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    // The locking edge samples a token, so the LOCKED
                    // timeout starts from zero just as for any later token.
                    if (w_run_done) begin
                        r_wcnt <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    if (!w_token) begin
                        r_rcnt <= '0;
                    end else if (r_rcnt != RCNT_FULL) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_token) begin
                        r_wcnt <= '0;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                    if (!w_token) begin
                        r_rcnt <= '0;
                    end else if (r_rcnt != RCNT_FULL) begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                ST_SLIP: begin
                    r_wcnt <= '0;
                    r_rcnt <= '0;
                    r_scnt <= '0;
                end
                ST_SETTLE: begin
                    r_wcnt <= '0;
                    r_rcnt <= '0;
                    r_scnt <= r_scnt + 1'b1;
                end
                default: begin
                    r_wcnt <= '0;
                    r_rcnt <= '0;
                    r_scnt <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Registered outputs. aligned/bitslip are decoded from the next state so
    // they change on the same edge as the state itself.
    // ---------------------------------------------------------------------
    always_ff @(posedge pixelclk or posedge rst) begin
        if (rst) begin
            r_pdataout <= '0;
            r_aligned  <= 1'b0;
            r_bitslip  <= 1'b0;
            r_slipcnt  <= '0;
        end else begin
            r_pdataout <= bus.pdatain;
            r_aligned  <= (w_state_nxt == ST_LOCKED);
            r_bitslip  <= (w_state_nxt == ST_SLIP);
            if (r_state == ST_SLIP) begin
                r_slipcnt <= (r_slipcnt == 4'd9) ? 4'd0 : r_slipcnt + 1'b1;
            end
        end
    end

    assign bus.pdataout = r_pdataout;
    assign bus.aligned  = r_aligned;
    assign bus.bitslip  = r_bitslip;
    assign bus.slipcnt  = r_slipcnt;

`ifdef ALIGN_LOCKLOSSCNT_EN
    logic [15:0] r_locklosscnt;

    always_ff @(posedge pixelclk or posedge rst) begin
        if (rst) begin
            r_locklosscnt <= '0;
        end else if ((r_state == ST_LOCKED) && (w_state_nxt == ST_SLIP) &&
                     (r_locklosscnt != '1)) begin
            r_locklosscnt <= r_locklosscnt + 1'b1;
        end
    end

    assign bus.locklosscnt = r_locklosscnt;
`endif

endmodule

// File: tb/tb_tmds_word_aligner.sv
module tb_tmds_word_aligner;

    logic pixelclk = 1'b0;
    logic rst      = 1'b1;

    always #5 pixelclk = ~pixelclk;

    tmds_word_aligner_if #(.KPARALLELWIDTH(10)) bus_a ();
    tmds_word_aligner_if #(.KPARALLELWIDTH(10)) bus_b ();

    tmds_word_aligner u_dut (
        .pixelclk (pixelclk),
        .rst      (rst),
        .bus      (bus_a)
    );

    tmds_word_aligner #(
        .KCTLTKNCOUNT  (4),
        .KSEARCHCYCLES (8)
    ) u_small (
        .pixelclk (pixelclk),
        .rst      (rst),
        .bus      (bus_b)
    );

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int unsigned off;
    logic        bs_prev;
    logic        rnd_mode;
    logic        sb_en;
    logic        aligned_seen;
    logic [9:0]  tx;
    logic [9:0]  sb[$];
    int          slip_cyc[$];
    logic [3:0]  slip_seq[$];

    typedef struct {
        logic [9:0] din;
        logic       al;
        logic       bs;
        logic [3:0] sc;
    } vec_t;

    vec_t tbl[25];

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
    endfunction

    // Deserializer with the word boundary shifted by k bits.
    function automatic logic [9:0] rot(input logic [9:0] w, input int unsigned k);
        logic [9:0] r;
        for (int unsigned i = 0; i < 10; i++) begin
            r[i] = w[(i + k) % 10];
        end
        return r;
    endfunction

    task automatic drive_a(input logic [9:0] w);
        bus_a.pdatain = w;
        if (sb_en) sb.push_back(w);
        else sb.delete();
    endtask

    // One clock: sample outputs 1 unit after the edge, update the
    // deserializer model, then drive the next word.
    task automatic tick();
        logic [9:0] w;
        logic [9:0] exp_w;
        @(posedge pixelclk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            exp_w = sb.pop_front();
            check("pdataout", 32'(bus_a.pdataout), 32'(exp_w));
        end
        if (bs_prev) begin
            off = (off + 1) % 10;
            slip_seq.push_back(bus_a.slipcnt);
        end
        bs_prev = bus_a.bitslip;
        if (bus_a.bitslip) slip_cyc.push_back(cyc);
        if (bus_a.aligned) aligned_seen = 1'b1;
        if (rnd_mode) begin
            do w = 10'($urandom_range(0, 1023)); while (is_token(w));
        end else begin
            w = rot(tx, off);
        end
        drive_a(w);
    endtask

    // Hold reset, check reset values, release on a falling edge.
    task automatic start(input int unsigned o, input logic [9:0] t);
        rst          = 1'b1;
        off          = o;
        tx           = t;
        bs_prev      = 1'b0;
        rnd_mode     = 1'b0;
        aligned_seen = 1'b0;
        cyc          = 0;
        sb.delete();
        slip_cyc.delete();
        slip_seq.delete();
        bus_b.pdatain = 10'h000;
        repeat (2) @(posedge pixelclk);
        #1;
        check("rst_pdataout", 32'(bus_a.pdataout), 32'd0);
        check("rst_aligned",  32'(bus_a.aligned),  32'd0);
        check("rst_bitslip",  32'(bus_a.bitslip),  32'd0);
        check("rst_slipcnt",  32'(bus_a.slipcnt),  32'd0);
        check("rst_b_aligned", 32'(bus_b.aligned), 32'd0);
`ifdef ALIGN_LOCKLOSSCNT_EN
        check("rst_locklosscnt", 32'(bus_a.locklosscnt), 32'd0);
`endif
        drive_a(rot(tx, off));
        @(negedge pixelclk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int last;
        int exp_seq[11];

        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};

        // Small instance: KCTLTKNCOUNT=4, KSEARCHCYCLES=8, KSETTLECYCLES=4.
        // Row i is sampled by edge i after reset release.
        for (int i = 0; i < 25; i++) begin
            tbl[i].din = 10'h000;
            tbl[i].al  = 1'b0;
            tbl[i].bs  = 1'b0;
            tbl[i].sc  = (i >= 16) ? 4'd1 : 4'd0;
        end
        tbl[4].din = 10'h354;  tbl[5].din = 10'h0AB;
        tbl[6].din = 10'h154;  tbl[7].din = 10'h2AB;   // run completes on timeout edge
        for (int i = 7; i <= 14; i++) tbl[i].al = 1'b1;
        tbl[15].bs = 1'b1;                             // 8th non-token after lock
        for (int i = 17; i <= 24; i++) tbl[i].din = (i % 2 == 0) ? 10'h354 : 10'h2AB;
        tbl[24].al = 1'b1;                             // 4th token after SETTLE

        sb_en = 1'b1;
        start(0, 10'h354);
        for (int i = 0; i < 25; i++) begin
            bus_b.pdatain = tbl[i].din;
            tick();
            check($sformatf("small_aligned[%0d]", i), 32'(bus_b.aligned), 32'(tbl[i].al));
            check($sformatf("small_bitslip[%0d]", i), 32'(bus_b.bitslip), 32'(tbl[i].bs));
            check($sformatf("small_slipcnt[%0d]", i), 32'(bus_b.slipcnt), 32'(tbl[i].sc));
        end

        // Aligned stream from reset release: lock on the 128th edge.
        start(0, 10'h354);
        repeat (127) tick();
        check("lock_before_128", 32'(bus_a.aligned), 32'd0);
        tick();
        check("lock_at_128", 32'(bus_a.aligned), 32'd1);
        check("aligned_no_slip", 32'(slip_cyc.size()), 32'd0);
        check("aligned_slipcnt", 32'(bus_a.slipcnt), 32'd0);

        // Lock loss: tokens, then non-tokens only.
        repeat (126) tick();
        tx = 10'h000;
        tick();
        last = cyc;
        n = 0;
        while (bus_a.aligned && n < 5000) begin
            tick();
            n++;
        end
        check("lockloss_fell", 32'(bus_a.aligned), 32'd0);
        check("lockloss_delay", 32'(cyc - last), 32'd4096);
        check("lockloss_bitslip", 32'(bus_a.bitslip), 32'd1);
        check("lockloss_one_pulse", 32'(slip_cyc.size()), 32'd1);
`ifdef ALIGN_LOCKLOSSCNT_EN
        check("locklosscnt", 32'(bus_a.locklosscnt), 32'd1);
`endif
        tick();
        check("lockloss_bitslip_end", 32'(bus_a.bitslip), 32'd0);
        check("lockloss_slipcnt", 32'(bus_a.slipcnt), 32'd1);

        // Boundary 3 slips away from alignment.
        sb_en = 1'b0;
        start(7, 10'h354);
        n = 0;
        while (!bus_a.aligned && n < 13000) begin
            tick();
            n++;
        end
        check("slip3_aligned", 32'(bus_a.aligned), 32'd1);
        check("slip3_pulses", 32'(slip_cyc.size()), 32'd3);
        check("slip3_slipcnt", 32'(bus_a.slipcnt), 32'd3);
        check("slip3_lock_cycle", 32'(cyc), 32'd12431);
        if (slip_cyc.size() >= 3) begin
            check("slip3_first", 32'(slip_cyc[0]), 32'd4096);
            check("slip3_gap1", 32'(slip_cyc[1] - slip_cyc[0]), 32'd4101);
            check("slip3_gap2", 32'(slip_cyc[2] - slip_cyc[1]), 32'd4101);
        end

        // Random non-token data for 11 windows.
        start(0, 10'h000);
        rnd_mode = 1'b1;
        n = 0;
        while (slip_cyc.size() < 11 && n < 46000) begin
            tick();
            n++;
        end
        tick();
        check("rand_pulses", 32'(slip_cyc.size()), 32'd11);
        check("rand_never_aligned", 32'(aligned_seen), 32'd0);
        for (int i = 0; i < 11; i++) begin
            if (i < slip_seq.size())
                check($sformatf("rand_slipcnt[%0d]", i), 32'(slip_seq[i]), 32'(exp_seq[i]));
            else
                check($sformatf("rand_slipcnt_missing[%0d]", i), 32'd0, 32'd1);
        end

        // Reset during the SLIP cycle.
        n = 0;
        while (!bus_a.bitslip && n < 4200) begin
            tick();
            n++;
        end
        check("pre_rst_bitslip", 32'(bus_a.bitslip), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_slip_bitslip", 32'(bus_a.bitslip), 32'd0);
        check("rst_slip_slipcnt", 32'(bus_a.slipcnt), 32'd0);
        check("rst_slip_pdataout", 32'(bus_a.pdataout), 32'd0);
        check("rst_slip_aligned", 32'(bus_a.aligned), 32'd0);

        // Restart, lock, then reset during LOCKED.
        start(0, 10'h354);
        repeat (128) tick();
        check("restart_aligned", 32'(bus_a.aligned), 32'd1);
        check("restart_slipcnt", 32'(bus_a.slipcnt), 32'd0);
        check("restart_no_slip", 32'(slip_cyc.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_lock_aligned", 32'(bus_a.aligned), 32'd0);
        check("rst_lock_pdataout", 32'(bus_a.pdataout), 32'd0);
        check("rst_lock_bitslip", 32'(bus_a.bitslip), 32'd0);
        check("rst_lock_b_aligned", 32'(bus_b.aligned), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
